// File: rtl/mips_core_pkg.sv
// Shared types for the branch-predictor update path.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package mips_core_pkg;

  // Table index width carried inside a queued update.
  localparam int BP_INDEX_WIDTH = 4;

  // Counter value written into every entry by an init sweep (weakly taken).
  localparam logic [1:0] BP_INIT_COUNTER = 2'b10;

  // One pending predictor update as held in the scheduler queue.
  typedef struct packed {
    logic [BP_INDEX_WIDTH-1:0] index;
    logic                      taken;
    logic                      correct;
  } bp_update_t;

  // Scheduler top-level state.
  typedef enum logic {
    SCHED_INIT,
    SCHED_RUN
  } sched_state_t;

endpackage

// File: rtl/bp_update_fifo.sv
// In-order update queue: two ordered push ports (port0 lands first), one pop port.
// Latency: a pushed entry is visible at o_head the cycle after it is written.
// Backpressure: none internally; the caller must never push past full or pop when empty.
module bp_update_fifo
  import mips_core_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                     i_clk,
  input  logic                     i_rst,
  input  logic                     i_clr,
  input  logic                     i_push0,
  input  bp_update_t               i_dat0,
  input  logic                     i_push1,
  input  bp_update_t               i_dat1,
  input  logic                     i_pop,
  output bp_update_t               o_head,
  output logic [$clog2(DEPTH):0]   o_count
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  bp_update_t    r_mem [DEPTH];
  logic [PW-1:0] r_wr_ptr;
  logic [PW-1:0] r_rd_ptr;
  logic [CW-1:0] r_count;
  logic [PW-1:0] w_wr_ptr1;

  // Port1 goes in the slot after port0 when both push, so the older entry stays ahead.
  assign w_wr_ptr1 = i_push0 ? r_wr_ptr + PW'(1) : r_wr_ptr;

  // Storage array; contents are don't-care until pointed at, so it carries no reset.
  always_ff @(posedge i_clk) begin
    if (i_push0) r_mem[r_wr_ptr] <= i_dat0;
    if (i_push1) r_mem[w_wr_ptr1] <= i_dat1;
  end

  // Pointers wrap naturally (power-of-two depth); full/empty come only from r_count.
  always_ff @(posedge i_clk) begin
    if (i_rst || i_clr) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      r_wr_ptr <= r_wr_ptr + PW'(i_push0) + PW'(i_push1);
      r_rd_ptr <= r_rd_ptr + PW'(i_pop);
      r_count  <= r_count + CW'(i_push0) + CW'(i_push1) - CW'(i_pop);
    end
  end

  assign o_head  = r_mem[r_rd_ptr];
  assign o_count = r_count;

endmodule

// File: rtl/bp_update_sched.sv
// Orders resolved-branch updates (execute before decode) onto the predictor's single write port and runs table init sweeps.
// Latency: update accepted in cycle t into an empty queue is written in t+2; one write per cycle sustained.
// Backpressure: readys from registered occupancy only; dec needs two free slots, ex one; both low during init, flush and reset.
module bp_update_sched
  import mips_core_pkg::*;
#(
  parameter int INDEX_WIDTH = BP_INDEX_WIDTH,
  parameter int ADDR_WIDTH  = 26,
  parameter int QUEUE_DEPTH = 4
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           ex_upd_valid,
  output logic                           ex_upd_ready,
  input  logic [ADDR_WIDTH-1:0]          ex_upd_pc,
  input  logic                           ex_upd_taken,
  input  logic                           ex_upd_correct,
  input  logic                           dec_upd_valid,
  output logic                           dec_upd_ready,
  input  logic [ADDR_WIDTH-1:0]          dec_upd_pc,
  input  logic                           dec_upd_taken,
  input  logic                           dec_upd_correct,
  input  logic                           flush_req,
  output logic                           bp_we,
  output logic                           bp_init,
  output logic [INDEX_WIDTH-1:0]         bp_write_index,
  output logic                           bp_write_taken,
  output logic                           bp_write_correct,
  output logic                           bp_busy,
  output logic [$clog2(QUEUE_DEPTH):0]   queue_count
);

  localparam int                     CW       = $clog2(QUEUE_DEPTH) + 1;
  localparam logic [INDEX_WIDTH-1:0] LAST_IDX = '1;

  sched_state_t           r_state, w_state_nxt;
  logic [INDEX_WIDTH-1:0] r_sweep_idx, w_sweep_nxt;
  logic                   w_we_nxt, w_init_nxt, w_taken_nxt, w_correct_nxt, w_busy_nxt;
  logic [INDEX_WIDTH-1:0] w_idx_nxt;
  logic [CW-1:0]          w_count;
  bp_update_t             w_head, w_ex_dat, w_dec_dat;
  logic                   w_accept_ok, w_ex_acc, w_dec_acc, w_pop;
  logic [2*(ADDR_WIDTH-INDEX_WIDTH)-1:0] w_unused_pc;

  // Only the low PC bits index the table.
  assign w_unused_pc = {ex_upd_pc[ADDR_WIDTH-1:INDEX_WIDTH], dec_upd_pc[ADDR_WIDTH-1:INDEX_WIDTH]};

  assign w_accept_ok   = (r_state == SCHED_RUN) && !rst && !flush_req;
  assign ex_upd_ready  = w_accept_ok && (w_count < CW'(QUEUE_DEPTH));
  assign dec_upd_ready = w_accept_ok && (w_count < CW'(QUEUE_DEPTH - 1));
  assign w_ex_acc      = ex_upd_valid && ex_upd_ready;
  assign w_dec_acc     = dec_upd_valid && dec_upd_ready;
  assign w_pop         = (r_state == SCHED_RUN) && !flush_req && (w_count != '0);

  assign w_ex_dat  = '{index: ex_upd_pc[INDEX_WIDTH-1:0], taken: ex_upd_taken, correct: ex_upd_correct};
  assign w_dec_dat = '{index: dec_upd_pc[INDEX_WIDTH-1:0], taken: dec_upd_taken, correct: dec_upd_correct};

  bp_update_fifo #(
    .DEPTH (QUEUE_DEPTH)
  ) u_fifo (
    .i_clk   (clk),
    .i_rst   (rst),
    .i_clr   (flush_req),
    .i_push0 (w_ex_acc),
    .i_dat0  (w_ex_dat),
    .i_push1 (w_dec_acc),
    .i_dat1  (w_dec_dat),
    .i_pop   (w_pop),
    .o_head  (w_head),
    .o_count (w_count)
  );

  // Next state and next write-port values; flush issues init index 0 itself, so the sweep resumes at 1.
  always_comb begin
    w_state_nxt   = r_state;
    w_sweep_nxt   = r_sweep_idx;
    w_we_nxt      = 1'b0;
    w_init_nxt    = 1'b0;
    w_idx_nxt     = '0;
    w_taken_nxt   = 1'b0;
    w_correct_nxt = 1'b0;
    if (flush_req) begin
      w_state_nxt = SCHED_INIT;
      w_sweep_nxt = INDEX_WIDTH'(1);
      w_we_nxt    = 1'b1;
      w_init_nxt  = 1'b1;
    end else begin
      case (r_state)
        SCHED_INIT: begin
          w_we_nxt    = 1'b1;
          w_init_nxt  = 1'b1;
          w_idx_nxt   = r_sweep_idx;
          w_sweep_nxt = r_sweep_idx + INDEX_WIDTH'(1);
          if (r_sweep_idx == LAST_IDX) w_state_nxt = SCHED_RUN;
        end
        SCHED_RUN: begin
          if (w_pop) begin
            w_we_nxt      = 1'b1;
            w_idx_nxt     = w_head.index;
            w_taken_nxt   = w_head.taken;
            w_correct_nxt = w_head.correct;
          end
        end
        default: ;
      endcase
    end
    // Busy stays high through the last init write and drops with the first RUN cycle's output.
    w_busy_nxt = w_init_nxt || (w_state_nxt == SCHED_INIT);
  end

  // State, sweep counter and registered write port; reset wins over flush.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state          <= SCHED_INIT;
      r_sweep_idx      <= '0;
      bp_we            <= 1'b0;
      bp_init          <= 1'b0;
      bp_write_index   <= '0;
      bp_write_taken   <= 1'b0;
      bp_write_correct <= 1'b0;
      bp_busy          <= 1'b1;
    end else begin
      r_state          <= w_state_nxt;
      r_sweep_idx      <= w_sweep_nxt;
      bp_we            <= w_we_nxt;
      bp_init          <= w_init_nxt;
      bp_write_index   <= w_idx_nxt;
      bp_write_taken   <= w_taken_nxt;
      bp_write_correct <= w_correct_nxt;
      bp_busy          <= w_busy_nxt;
    end
  end

  assign queue_count = w_count;

endmodule
